// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-mode encodings for the debounced Avalon-MM PIO.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_IN       = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter, debounced level and
// a single-cycle pulse on the clock edge where the debounced level changes.
module pio_debounce_bit
    import avalon_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b0,
    parameter int   EDGE_MODE       = EDGE_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic edge_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_s;
    logic [CW-1:0] cnt;
    logic          commit;

    // commit is true exactly on the cycle whose clock edge updates deb, so the
    // edge pulse lines up with the change and a reset never produces one
    assign commit = (sync_s != deb) && (cnt == CNT_LAST);

    always_comb begin
        case (EDGE_MODE)
            EDGE_FALL: edge_pulse = commit && !sync_s;
            EDGE_BOTH: edge_pulse = commit;
            default:   edge_pulse = commit && sync_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= RESET_VAL;
            sync_s    <= RESET_VAL;
            deb       <= RESET_VAL;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_s    <= sync_meta;
            if (sync_s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/avalon_pio_debounced.sv
// Avalon-MM PIO slave: debounced input bank with sticky edge capture and a
// maskable level interrupt, plus an output latch with set/clear aliases.
module avalon_pio_debounced
    import avalon_pio_pkg::*;
#(
    parameter int              IN_W            = 3,
    parameter int              OUT_W           = 18,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_W-1:0] IN_RESET_VAL    = '0,
    parameter logic [OUT_W-1:0] OUT_RESET_VAL  = '0,
    parameter int              EDGE_MODE       = EDGE_RISE
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [IN_W-1:0]  in_export,
    output logic [OUT_W-1:0] out_export
);

    logic [IN_W-1:0]  deb;
    logic [IN_W-1:0]  edge_pulse;
    logic [IN_W-1:0]  edge_cap;
    logic [IN_W-1:0]  irq_mask;
    logic [IN_W-1:0]  w1c;
    logic [OUT_W-1:0] out_reg;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    for (genvar i = 0; i < IN_W; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (IN_RESET_VAL[i]),
            .EDGE_MODE      (EDGE_MODE)
        ) u_bit (
            .clk       (clk_clk),
            .rst       (reset_reset),
            .raw       (in_export[i]),
            .deb       (deb[i]),
            .edge_pulse(edge_pulse[i])
        );
    end

    assign out_export = out_reg;
    assign unused_wd  = &{1'b0, avs_writedata};
    assign w1c = (avs_write && (avs_address == ADDR_EDGE_CAP)) ? avs_writedata[IN_W-1:0] : '0;

    // write-only and reserved addresses fall through to zero
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_IN:       rd_mux[IN_W-1:0]  = deb;
            ADDR_OUT:      rd_mux[OUT_W-1:0] = out_reg;
            ADDR_IRQ_MASK: rd_mux[IN_W-1:0]  = irq_mask;
            ADDR_EDGE_CAP: rd_mux[IN_W-1:0]  = edge_cap;
            default:       rd_mux = '0;
        endcase
    end

    // readdata samples pre-write state, so a simultaneous read and write returns the old value;
    // a new edge is OR-ed in after the clear so a colliding capture survives
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            out_reg      <= OUT_RESET_VAL;
            irq_mask     <= '0;
            edge_cap     <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    ADDR_OUT:      out_reg  <= avs_writedata[OUT_W-1:0];
                    ADDR_OUT_SET:  out_reg  <= out_reg | avs_writedata[OUT_W-1:0];
                    ADDR_OUT_CLR:  out_reg  <= out_reg & ~avs_writedata[OUT_W-1:0];
                    ADDR_IRQ_MASK: irq_mask <= avs_writedata[IN_W-1:0];
                    default:       ;
                endcase
            end
            edge_cap <= (edge_cap & ~w1c) | edge_pulse;
            irq      <= |(edge_cap & irq_mask);
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule
